// File: rtl/recall_if.sv
// recall_if: groups the signals of the recall block.
//   Command side : recall, count (in), busy, done (out)
//   Memory port  : r_en, r_addr (out), r_ready, r_data (in)
//   Output stream: out_valid, out_data (out), out_ready (in)
// Modports:
//   master - the recall block itself (drives requests and the output stream)
//   slave  - its environment (command source, word memory, playback sink)
interface recall_if #(
  parameter int WORD_SIZE    = 8,
  parameter int ADDRESS_SIZE = 4
);
  logic                    recall;
  logic [ADDRESS_SIZE:0]   count;
  logic                    r_ready;
  logic [WORD_SIZE-1:0]    r_data;
  logic                    out_ready;
  logic                    r_en;
  logic [ADDRESS_SIZE-1:0] r_addr;
  logic                    out_valid;
  logic [WORD_SIZE-1:0]    out_data;
  logic                    busy;
  logic                    done;

  modport master (
    input  recall, count, r_ready, r_data, out_ready,
    output r_en, r_addr, out_valid, out_data, busy, done
  );

  modport slave (
    output recall, count, r_ready, r_data, out_ready,
    input  r_en, r_addr, out_valid, out_data, busy, done
  );
endinterface

// File: rtl/recall.sv
// recall: reads a block of words from the shared word memory, starting at
// address 0 and counting upward, and streams them to the playback/compare
// logic. Each word is fetched with a request/ready read handshake and then
// offered downstream with a valid/ready handshake; done pulses for one cycle
// when the block is complete.
// Ports:
//   clock - system clock, all state on the rising edge
//   reset - asynchronous, active-low reset
//   bus   - recall_if.master: recall/count/busy/done command signals,
//           r_en/r_addr/r_ready/r_data memory read port,
//           out_valid/out_data/out_ready output stream
// All outputs are registered.
module recall #(
  parameter int WORD_SIZE    = 8,
  parameter int ADDRESS_SIZE = 4,
  parameter int MEMORY_QTY   = 16
) (
  input  logic     clock,
  input  logic     reset,
  recall_if.master bus
);

  localparam int CW = ADDRESS_SIZE + 1;

  typedef enum logic [1:0] {IDLE, READ, OUTPUT, DONE} state_t;

  state_t                  state, state_nxt;
  logic [CW-1:0]           len, len_nxt;
  logic [CW-1:0]           index, index_nxt;
  logic                    r_en_q, r_en_nxt;
  logic [ADDRESS_SIZE-1:0] r_addr_q, r_addr_nxt;
  logic                    out_valid_q, out_valid_nxt;
  logic [WORD_SIZE-1:0]    out_data_q, out_data_nxt;
  logic                    busy_q, busy_nxt;
  logic                    done_q, done_nxt;

  // Clamping the block length to the memory size keeps r_addr in range
  // without needing any wrap logic.
  function automatic logic [CW-1:0] clamp_len(input logic [CW-1:0] c);
    return (c > CW'(MEMORY_QTY)) ? CW'(MEMORY_QTY) : c;
  endfunction

  function automatic logic is_last(input logic [CW-1:0] idx,
                                   input logic [CW-1:0] n);
    return idx == (n - CW'(1));
  endfunction

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        // A zero-length recall skips memory entirely and just reports done.
        if (bus.recall) state_nxt = (bus.count != '0) ? READ : DONE;
      end
      READ: begin
        if (r_en_q && bus.r_ready) state_nxt = OUTPUT;
      end
      OUTPUT: begin
        if (out_valid_q && bus.out_ready)
          state_nxt = is_last(index, len) ? DONE : READ;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output logic: next values of the registered outputs and block counters
  always_comb begin
    len_nxt       = len;
    index_nxt     = index;
    r_en_nxt      = r_en_q;
    r_addr_nxt    = r_addr_q;
    out_valid_nxt = out_valid_q;
    out_data_nxt  = out_data_q;
    busy_nxt      = busy_q;
    done_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.recall) begin
          if (bus.count != '0) begin
            len_nxt    = clamp_len(bus.count);
            index_nxt  = '0;
            r_addr_nxt = '0;
            r_en_nxt   = 1'b1;
            busy_nxt   = 1'b1;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end
      READ: begin
        // Request and address stay put until the memory acknowledges.
        if (r_en_q && bus.r_ready) begin
          out_data_nxt  = bus.r_data;
          out_valid_nxt = 1'b1;
          r_en_nxt      = 1'b0;
        end
      end
      OUTPUT: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_nxt = 1'b0;
          if (is_last(index, len)) begin
            busy_nxt = 1'b0;
            done_nxt = 1'b1;
          end else begin
            index_nxt  = index + CW'(1);
            r_addr_nxt = r_addr_q + ADDRESS_SIZE'(1);
            r_en_nxt   = 1'b1;
          end
        end
      end
      default: begin
      end
    endcase
  end

  // Output and counter registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      len         <= '0;
      index       <= '0;
      r_en_q      <= 1'b0;
      r_addr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      len         <= len_nxt;
      index       <= index_nxt;
      r_en_q      <= r_en_nxt;
      r_addr_q    <= r_addr_nxt;
      out_valid_q <= out_valid_nxt;
      out_data_q  <= out_data_nxt;
      busy_q      <= busy_nxt;
      done_q      <= done_nxt;
    end
  end

  assign bus.r_en      = r_en_q;
  assign bus.r_addr    = r_addr_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule
